// File: rtl/multi_room_light_ctrl.sv
// Multi-room occupancy light controller: per-room beam-pair direction FSM,
// saturating occupancy count, off-delay timer and global light override.
module multi_room_light_ctrl #(
  parameter int N_ROOMS   = 4,
  parameter int CNT_W     = 6,
  parameter int DLY_W     = 16,
  parameter int OFF_DELAY = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_ROOMS-1:0]         s1,
  input  logic [N_ROOMS-1:0]         s2,
  input  logic [1:0]                 mode,
  output logic [N_ROOMS-1:0]         light,
  output logic [N_ROOMS*CNT_W-1:0]   occupancy,
  output logic [N_ROOMS-1:0]         sat,
  output logic [N_ROOMS-1:0]         err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] IN1  = 3'd1;
  localparam logic [2:0] IN2  = 3'd2;
  localparam logic [2:0] IN3  = 3'd3;
  localparam logic [2:0] OUT1 = 3'd4;
  localparam logic [2:0] OUT2 = 3'd5;
  localparam logic [2:0] OUT3 = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(OFF_DELAY);

  logic [2:0]       state     [N_ROOMS];
  logic [2:0]       state_nxt [N_ROOMS];
  logic [CNT_W-1:0] count     [N_ROOMS];
  logic [DLY_W-1:0] timer     [N_ROOMS];
  logic [N_ROOMS-1:0] entry;
  logic [N_ROOMS-1:0] leave;

  always_comb begin
    entry = '0;
    leave = '0;
    for (int unsigned i = 0; i < N_ROOMS; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        IDLE: begin
          if ({s1[i], s2[i]} == 2'b10)      state_nxt[i] = IN1;
          else if ({s1[i], s2[i]} == 2'b01) state_nxt[i] = OUT1;
        end
        IN1: begin
          case ({s1[i], s2[i]})
            2'b11:   state_nxt[i] = IN2;
            2'b10:   state_nxt[i] = IN1;
            default: state_nxt[i] = IDLE;
          endcase
        end
        IN2: begin
          case ({s1[i], s2[i]})
            2'b01:   state_nxt[i] = IN3;
            2'b10:   state_nxt[i] = IN1;
            2'b11:   state_nxt[i] = IN2;
            default: state_nxt[i] = IDLE;
          endcase
        end
        IN3: begin
          case ({s1[i], s2[i]})
            2'b00: begin
              state_nxt[i] = IDLE;
              entry[i]     = 1'b1;
            end
            2'b11:   state_nxt[i] = IN2;
            2'b01:   state_nxt[i] = IN3;
            default: state_nxt[i] = IDLE;
          endcase
        end
        // Outbound path: same shape as inbound with s1/s2 roles swapped
        OUT1: begin
          case ({s1[i], s2[i]})
            2'b11:   state_nxt[i] = OUT2;
            2'b01:   state_nxt[i] = OUT1;
            default: state_nxt[i] = IDLE;
          endcase
        end
        OUT2: begin
          case ({s1[i], s2[i]})
            2'b10:   state_nxt[i] = OUT3;
            2'b01:   state_nxt[i] = OUT1;
            2'b11:   state_nxt[i] = OUT2;
            default: state_nxt[i] = IDLE;
          endcase
        end
        OUT3: begin
          case ({s1[i], s2[i]})
            2'b00: begin
              state_nxt[i] = IDLE;
              leave[i]     = 1'b1;
            end
            2'b11:   state_nxt[i] = OUT2;
            2'b10:   state_nxt[i] = OUT3;
            default: state_nxt[i] = IDLE;
          endcase
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_ROOMS; i++) begin
        state[i] <= IDLE;
        count[i] <= '0;
        timer[i] <= '0;
      end
      light <= '0;
      sat   <= '0;
      err   <= '0;
    end else begin
      for (int unsigned i = 0; i < N_ROOMS; i++) begin
        state[i] <= state_nxt[i];

        if (entry[i]) begin
          if (count[i] == CNT_MAX) sat[i]   <= 1'b1;
          else                     count[i] <= count[i] + 1'b1;
        end else if (leave[i] && count[i] != '0) begin
          count[i] <= count[i] - 1'b1;
        end
        err[i] <= leave[i] && (count[i] == '0);

        // Held at full load while occupied so a re-entry mid-countdown restarts it
        if (count[i] != '0)      timer[i] <= DLY_LOAD;
        else if (timer[i] != '0) timer[i] <= timer[i] - 1'b1;

        case (mode)
          2'b00:   light[i] <= (count[i] != '0) || (timer[i] != '0);
          2'b01:   light[i] <= 1'b1;
          2'b10:   light[i] <= 1'b0;
          default: light[i] <= (count[i] != '0);
        endcase
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < N_ROOMS; i++) begin
      occupancy[i*CNT_W +: CNT_W] = count[i];
    end
  end

endmodule

// File: tb/tb_multi_room_light_ctrl.sv
// Directed bench for multi_room_light_ctrl (4 rooms, 2-bit counts, 1000-cycle off-delay).
module tb_multi_room_light_ctrl;

  localparam int N_ROOMS   = 4;
  localparam int CNT_W     = 2;
  localparam int DLY_W     = 16;
  localparam int OFF_DELAY = 1000;

  localparam logic [7:0] ENTRY = 8'b10_11_01_00;
  localparam logic [7:0] EXIT  = 8'b01_11_10_00;
  localparam logic [7:0] ABORT = 8'b10_11_10_00;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_ROOMS-1:0]       s1, s2;
  logic [1:0]               mode;
  logic [N_ROOMS-1:0]       light;
  logic [N_ROOMS*CNT_W-1:0] occupancy;
  logic [N_ROOMS-1:0]       sat;
  logic [N_ROOMS-1:0]       err;

  int vectors = 0;
  int miscompares = 0;

  multi_room_light_ctrl #(
    .N_ROOMS  (N_ROOMS),
    .CNT_W    (CNT_W),
    .DLY_W    (DLY_W),
    .OFF_DELAY(OFF_DELAY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s1       (s1),
    .s2       (s2),
    .mode     (mode),
    .light    (light),
    .occupancy(occupancy),
    .sat      (sat),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply four {s1,s2} patterns (MSB pair first) to the rooms in mask, one per cycle
  task automatic drive_seq(input logic [N_ROOMS-1:0] mask, input logic [7:0] pats);
    logic [7:0] p;
    p = pats;
    for (int k = 3; k >= 0; k--) begin
      s1 = p[2*k+1] ? mask : '0;
      s2 = p[2*k]   ? mask : '0;
      step();
    end
    s1 = '0;
    s2 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    s1 = '0; s2 = '0; mode = 2'b00;
    step(); step();
    vectors++;
    if ({light, occupancy, sat, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got light=%b occ=%h sat=%b err=%b, want all 0",
               light, occupancy, sat, err);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_entry_auto_delay();
    bit dropped;
    mode = 2'b00;
    drive_seq(4'b0001, ENTRY);
    vectors++;
    if (occupancy !== 8'h01) begin
      miscompares++;
      $display("FAIL entry_count: got occ=%h, want 01", occupancy);
    end
    step();
    vectors++;
    if (light !== 4'b0001) begin
      miscompares++;
      $display("FAIL entry_light: got %b, want 0001", light);
    end
    drive_seq(4'b0001, EXIT);
    vectors++;
    if (occupancy !== 8'h00 || light !== 4'b0001) begin
      miscompares++;
      $display("FAIL exit_count: got occ=%h light=%b, want 00 / 0001", occupancy, light);
    end
    dropped = 1'b0;
    for (int j = 1; j <= OFF_DELAY; j++) begin
      step();
      if (light[0] !== 1'b1) dropped = 1'b1;
    end
    vectors++;
    if (dropped) begin
      miscompares++;
      $display("FAIL off_delay_hold: light0 dropped early, want held high %0d cycles", OFF_DELAY);
    end
    step();
    vectors++;
    if (light !== 4'b0000) begin
      miscompares++;
      $display("FAIL off_delay_expire: got %b, want 0000", light);
    end
  endtask

  task automatic test_mode_no_delay();
    mode = 2'b11;
    drive_seq(4'b0001, ENTRY);
    step();
    vectors++;
    if (occupancy !== 8'h01 || light !== 4'b0001) begin
      miscompares++;
      $display("FAIL nodelay_entry: got occ=%h light=%b, want 01 / 0001", occupancy, light);
    end
    drive_seq(4'b0001, EXIT);
    step();
    vectors++;
    if (occupancy !== 8'h00 || light !== 4'b0000) begin
      miscompares++;
      $display("FAIL nodelay_off: got occ=%h light=%b, want 00 / 0000", occupancy, light);
    end
    mode = 2'b01;
    step();
    vectors++;
    if (light !== 4'b1111) begin
      miscompares++;
      $display("FAIL force_on: got %b, want 1111", light);
    end
    mode = 2'b10;
    step();
    vectors++;
    if (light !== 4'b0000) begin
      miscompares++;
      $display("FAIL force_off: got %b, want 0000", light);
    end
    mode = 2'b11;
  endtask

  task automatic test_abort_and_err();
    logic [N_ROOMS-1:0] err_seen;
    err_seen = '0;
    for (int k = 3; k >= 0; k--) begin
      logic [7:0] p;
      p = ABORT;
      s1 = p[2*k+1] ? 4'b0010 : '0;
      s2 = p[2*k]   ? 4'b0010 : '0;
      step();
      err_seen |= err;
    end
    s1 = '0; s2 = '0;
    step();
    err_seen |= err;
    vectors++;
    if (occupancy !== 8'h00 || err_seen !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort: got occ=%h err_seen=%b, want 00 / 0000", occupancy, err_seen);
    end
    drive_seq(4'b0010, EXIT);
    vectors++;
    if (err !== 4'b0010 || occupancy !== 8'h00) begin
      miscompares++;
      $display("FAIL err_pulse: got err=%b occ=%h, want 0010 / 00", err, occupancy);
    end
    step();
    vectors++;
    if (err !== 4'b0000) begin
      miscompares++;
      $display("FAIL err_one_cycle: got err=%b, want 0000", err);
    end
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 3; n++) drive_seq(4'b0100, ENTRY);
    vectors++;
    if (occupancy !== 8'h30 || sat !== 4'b0000) begin
      miscompares++;
      $display("FAIL sat_at_max: got occ=%h sat=%b, want 30 / 0000", occupancy, sat);
    end
    drive_seq(4'b0100, ENTRY);
    vectors++;
    if (occupancy !== 8'h30 || sat !== 4'b0100) begin
      miscompares++;
      $display("FAIL sat_set: got occ=%h sat=%b, want 30 / 0100", occupancy, sat);
    end
    step(); step(); step();
    vectors++;
    if (sat !== 4'b0100) begin
      miscompares++;
      $display("FAIL sat_sticky: got sat=%b, want 0100", sat);
    end
  endtask

  task automatic test_reset_mid_sequence();
    mode = 2'b01;
    s1 = 4'b1000; s2 = 4'b0000; step();
    s1 = 4'b1000; s2 = 4'b1000; step();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({light, occupancy, sat, err} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got light=%b occ=%h sat=%b err=%b, want all 0",
               light, occupancy, sat, err);
    end
    step();
    reset = 1'b1;
    mode = 2'b11;
    s1 = 4'b0000; s2 = 4'b1000; step();
    s1 = 4'b0000; s2 = 4'b0000; step();
    step();
    vectors++;
    if (occupancy !== 8'h00 || err !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_reset_discard: got occ=%h err=%b, want 00 / 0000", occupancy, err);
    end
  endtask

  task automatic test_back_to_back();
    drive_seq(4'b1001, ENTRY);
    vectors++;
    if (occupancy !== 8'b01_00_00_01) begin
      miscompares++;
      $display("FAIL concurrent_entry: got occ=%b, want 01000001", occupancy);
    end
    step();
    vectors++;
    if (light !== 4'b1001) begin
      miscompares++;
      $display("FAIL concurrent_light: got %b, want 1001", light);
    end
  endtask

  initial begin
    test_reset();
    test_entry_auto_delay();
    test_mode_no_delay();
    test_abort_and_err();
    test_saturation();
    test_reset_mid_sequence();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
